// File: rtl/g_lfsr128_pkg.sv
// g_lfsr128_pkg
// Shared definitions for the 128-bit Galois LFSR generator and its
// receive-side checker. Both ends import this package so that the seed
// and feedback polynomial can never drift apart.
//   LFSR128_SEED  : reset value of the LFSR on both ends
//   LFSR128_TAP_* : stages that take s[0] as feedback on top of the shift
//   lfsr128_next  : one forward step of the LFSR
//   chk_state_t   : checker lock FSM states
package g_lfsr128_pkg;

   localparam logic [127:0] LFSR128_SEED  = 128'hc68d8f390b46dd048f9eb80572892b7d;
   localparam int           LFSR128_TAP_A = 98;
   localparam int           LFSR128_TAP_B = 100;
   localparam int           LFSR128_TAP_C = 125;

   typedef enum logic {
      HUNT,
      LOCKED
   } chk_state_t;

   // Shift toward stage 0, recirculate s[0] into stage 127 and fold it
   // into the three tap stages.
   function automatic logic [127:0] lfsr128_next(input logic [127:0] s);
      logic [127:0] n;
      n = {s[0], s[127:1]};
      n[LFSR128_TAP_A] = s[LFSR128_TAP_A + 1] ^ s[0];
      n[LFSR128_TAP_B] = s[LFSR128_TAP_B + 1] ^ s[0];
      n[LFSR128_TAP_C] = s[LFSR128_TAP_C + 1] ^ s[0];
      return n;
   endfunction

endpackage

// File: rtl/g_lfsr128_checker_if.sv
// g_lfsr128_checker_if
// Stream and status bundle between a bit-stream source and the checker.
//   bit_valid/bit_in : serial stream, one bit per valid cycle
//   clear            : synchronous clear of the two counters
//   locked/err_pulse : lock status and per-error pulse
//   bit_count/error_count : saturating counters, CNT_W bits wide
// master = stream source / status consumer, slave = checker.
interface g_lfsr128_checker_if #(
   parameter int CNT_W = 32
);

   logic             bit_valid;
   logic             bit_in;
   logic             clear;
   logic             locked;
   logic             err_pulse;
   logic [CNT_W-1:0] bit_count;
   logic [CNT_W-1:0] error_count;

   modport master (
      output bit_valid, bit_in, clear,
      input  locked, err_pulse, bit_count, error_count
   );

   modport slave (
      input  bit_valid, bit_in, clear,
      output locked, err_pulse, bit_count, error_count
   );

endinterface

// File: rtl/g_lfsr128_checker_sat_counter.sv
// sat_counter
// W-bit up counter that sticks at all-ones instead of wrapping.
//   clk, rst : clock and asynchronous active-high reset
//   inc      : add one this cycle (ignored once saturated)
//   clr      : synchronous clear, wins over inc
//   count    : current value
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   // Clear beats increment so a clear issued alongside a counted event
   // leaves the counter at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/g_lfsr128_checker.sv
// g_lfsr128_checker
// Receive-side checker for the 128-bit Galois LFSR pattern generator.
// Keeps a local LFSR copy, aligns it to the incoming serial stream from
// the common seed, and reports lock status plus bit and error counts.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of g_lfsr128_checker_if
//              (bit_valid, bit_in, clear in; locked, err_pulse,
//               bit_count, error_count out)
module g_lfsr128_checker
   import g_lfsr128_pkg::*;
#(
   parameter logic [127:0] SEED     = LFSR128_SEED,
   parameter int           LOCK_LEN = 64,
   parameter int           LOSS_LEN = 8,
   parameter int           CNT_W    = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   g_lfsr128_checker_if.slave     bus
);

   localparam logic [8:0]   LOCK_CMP  = 9'(LOCK_LEN);
   localparam logic [8:0]   LOSS_CMP  = 9'(LOSS_LEN);
   localparam logic [127:0] SEED_NEXT = lfsr128_next(SEED);

   chk_state_t   state, state_n;
   logic [127:0] s, s_n;
   logic [7:0]   run, run_n;
   logic [7:0]   miss, miss_n;
   logic         err_n;
   logic         err_pulse_q;
   logic [8:0]   run_inc;
   logic [8:0]   miss_inc;
   logic         mismatch;

   assign run_inc  = {1'b0, run} + 9'd1;
   assign miss_inc = {1'b0, miss} + 9'd1;
   assign mismatch = bus.bit_in != s[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= HUNT;
         s           <= SEED;
         run         <= '0;
         miss        <= '0;
         err_pulse_q <= 1'b0;
      end else begin
         state       <= state_n;
         s           <= s_n;
         run         <= run_n;
         miss        <= miss_n;
         err_pulse_q <= err_n;
      end
   end

   // In HUNT a mismatching bit equal to SEED[0] is taken as the first
   // bit of a restarted stream, so the local copy jumps straight to
   // next(SEED) with one match already banked. In LOCKED the local LFSR
   // free-runs with the stream and only a run of misses drops lock.
   always_comb begin
      state_n = state;
      s_n     = s;
      run_n   = run;
      miss_n  = miss;
      err_n   = 1'b0;
      if (bus.bit_valid) begin
         unique case (state)
            HUNT: begin
               if (!mismatch) begin
                  s_n = lfsr128_next(s);
                  if (run_inc == LOCK_CMP) begin
                     state_n = LOCKED;
                     run_n   = '0;
                     miss_n  = '0;
                  end else begin
                     run_n = run_inc[7:0];
                  end
               end else if (bus.bit_in == SEED[0]) begin
                  s_n   = SEED_NEXT;
                  run_n = 8'd1;
                  if (LOCK_CMP == 9'd1) begin
                     state_n = LOCKED;
                     run_n   = '0;
                     miss_n  = '0;
                  end
               end else begin
                  s_n   = SEED;
                  run_n = '0;
               end
            end
            LOCKED: begin
               s_n = lfsr128_next(s);
               if (!mismatch) begin
                  miss_n = '0;
               end else begin
                  err_n = 1'b1;
                  if (miss_inc == LOSS_CMP) begin
                     state_n = HUNT;
                     s_n     = SEED;
                     run_n   = '0;
                     miss_n  = '0;
                  end else begin
                     miss_n = miss_inc[7:0];
                  end
               end
            end
            default: begin
               state_n = HUNT;
            end
         endcase
      end
   end

   assign bus.locked    = (state == LOCKED);
   assign bus.err_pulse = err_pulse_q;

   sat_counter #(.W(CNT_W)) u_bit_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (bus.bit_valid),
      .clr   (bus.clear),
      .count (bus.bit_count)
   );

   sat_counter #(.W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (err_n),
      .clr   (bus.clear),
      .count (bus.error_count)
   );

endmodule
